link_allocator: RTL and testbench

//  Link-allocation (LA) stage directly downstream of wb_slave_interface: arbitrates which out-buffer

---
 rtl/link_allocator_pkg.sv | 27 ++
 rtl/link_allocator_if.sv | 24 ++
 rtl/link_allocator_rr_arbiter.sv | 26 ++
 rtl/link_allocator.sv | 123 ++++++++++++
 tb/tb_link_allocator.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/link_allocator_pkg.sv
// Shared parameters and types for the NIC link-allocation stage.
// Build macros: LA_CREDIT_MAX (credits per VC after reset, default 8).
`ifndef LA_CREDIT_MAX
`define LA_CREDIT_MAX 8
`endif

package link_allocator_pkg;

  localparam int unsigned N_OF_VN                = 2;
  localparam int unsigned N_OF_VC                = 2;
  localparam int unsigned N_FIFO_OUT_BUFFER      = 6;
  localparam int unsigned N_BITS_FIFO_OUT_BUFFER = $clog2(N_FIFO_OUT_BUFFER);
  localparam int unsigned N_TOT_OF_VC            = N_OF_VN * N_OF_VC;
  localparam int unsigned N_BITS_VC_ID           = $clog2(N_TOT_OF_VC);
  localparam int unsigned N_BITS_CREDIT          = 4;
  localparam int unsigned CREDIT_MAX             = `LA_CREDIT_MAX;

  typedef logic [N_BITS_FIFO_OUT_BUFFER-1:0] buf_id_t;
  typedef logic [N_BITS_VC_ID-1:0]           vc_id_t;
  typedef logic [N_BITS_CREDIT-1:0]          credit_t;

  typedef enum logic {
    LOCK_IDLE,
    LOCK_HELD
  } lock_state_t;

endpackage

// File: rtl/link_allocator_if.sv
// Out-buffer request / credit / grant bundle between the out-buffers and link_allocator.
interface link_allocator_if;
  import link_allocator_pkg::*;

  logic [N_FIFO_OUT_BUFFER-1:0]              r_la_i;
  logic [N_FIFO_OUT_BUFFER*N_BITS_VC_ID-1:0] buffer_vc_i;
  logic [N_FIFO_OUT_BUFFER-1:0]              buffer_tail_i;
  logic [N_TOT_OF_VC-1:0]                    credit_in_i;
  logic                                      g_la_o;
  logic [N_BITS_FIFO_OUT_BUFFER-1:0]         g_la_fifo_out_buffer_id_o;
  logic [N_TOT_OF_VC-1:0]                    credit_available_o;
  logic                                      credit_overflow_o;

  modport master (
    output r_la_i, buffer_vc_i, buffer_tail_i, credit_in_i,
    input  g_la_o, g_la_fifo_out_buffer_id_o, credit_available_o, credit_overflow_o
  );

  modport slave (
    input  r_la_i, buffer_vc_i, buffer_tail_i, credit_in_i,
    output g_la_o, g_la_fifo_out_buffer_id_o, credit_available_o, credit_overflow_o
  );

endinterface

// File: rtl/link_allocator_rr_arbiter.sv
// la_rr_arbiter: combinational rotate-priority arbiter; first request at or after ptr wins.
module la_rr_arbiter
  import link_allocator_pkg::*;
(
  input  logic [N_FIFO_OUT_BUFFER-1:0] req,
  input  buf_id_t                      ptr,
  output logic                         grant,
  output buf_id_t                      id
);

  int unsigned idx;

  always_comb begin
    grant = 1'b0;
    id    = '0;
    idx   = 0;
    for (int unsigned i = 0; i < N_FIFO_OUT_BUFFER; i++) begin
      idx = (int'(ptr) + i) % N_FIFO_OUT_BUFFER;
      if (!grant && req[idx]) begin
        grant = 1'b1;
        id    = N_BITS_FIFO_OUT_BUFFER'(idx);
      end
    end
  end

endmodule

// File: rtl/link_allocator.sv
// link_allocator: credit-aware round-robin grant of the NIC->router flit link.
// Build macros: LA_PACKET_LOCK_EN (wormhole lock on multi-flit packets).
module link_allocator
  import link_allocator_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  link_allocator_if.slave bus
);

  credit_t                      credit [N_TOT_OF_VC];
  buf_id_t                      rr_ptr;
  logic                         overflow;
  logic [N_FIFO_OUT_BUFFER-1:0] lock_mask;
  logic [N_FIFO_OUT_BUFFER-1:0] eligible;
  logic                         arb_valid;
  buf_id_t                      arb_id;
  logic                         grant;
  vc_id_t                       win_vc;
  logic                         win_tail;
  logic                         ptr_adv;

  always_comb begin
    eligible = '0;
    win_vc   = '0;
    win_tail = 1'b0;
    for (int unsigned b = 0; b < N_FIFO_OUT_BUFFER; b++) begin
      eligible[b] = bus.r_la_i[b] && lock_mask[b] &&
                    (credit[bus.buffer_vc_i[b*N_BITS_VC_ID +: N_BITS_VC_ID]] != '0);
      if (buf_id_t'(b) == arb_id) begin
        win_vc   = bus.buffer_vc_i[b*N_BITS_VC_ID +: N_BITS_VC_ID];
        win_tail = bus.buffer_tail_i[b];
      end
    end
  end

  la_rr_arbiter u_arb (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (arb_valid),
    .id    (arb_id)
  );

  assign grant = rst && arb_valid;

`ifdef LA_PACKET_LOCK_EN
  lock_state_t lock_state, lock_state_next;
  buf_id_t     lock_id, lock_id_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_state <= LOCK_IDLE;
      lock_id    <= '0;
    end else begin
      lock_state <= lock_state_next;
      lock_id    <= lock_id_next;
    end
  end

  // While held only the locked buffer can be eligible, so any grant is its flit.
  always_comb begin
    lock_state_next = lock_state;
    lock_id_next    = lock_id;
    ptr_adv         = 1'b0;
    if (grant) begin
      if (win_tail) begin
        lock_state_next = LOCK_IDLE;
        ptr_adv         = 1'b1;
      end else begin
        lock_state_next = LOCK_HELD;
        lock_id_next    = arb_id;
      end
    end
  end

  always_comb begin
    lock_mask = '0;
    for (int unsigned b = 0; b < N_FIFO_OUT_BUFFER; b++) begin
      lock_mask[b] = (lock_state == LOCK_IDLE) || (lock_id == buf_id_t'(b));
    end
  end
`else
  logic tail_unused;
  assign tail_unused = win_tail;
  assign lock_mask   = '1;
  assign ptr_adv     = grant;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned v = 0; v < N_TOT_OF_VC; v++) begin
        credit[v] <= N_BITS_CREDIT'(CREDIT_MAX);
      end
      rr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      // A grant and a return on the same VC cancel, so no overflow can arise from that pair.
      for (int unsigned v = 0; v < N_TOT_OF_VC; v++) begin
        if (bus.credit_in_i[v] && !(grant && win_vc == vc_id_t'(v))) begin
          if (credit[v] == N_BITS_CREDIT'(CREDIT_MAX)) overflow <= 1'b1;
          else                                         credit[v] <= credit[v] + 1'b1;
        end else if (!bus.credit_in_i[v] && grant && win_vc == vc_id_t'(v)) begin
          credit[v] <= credit[v] - 1'b1;
        end
      end
      if (ptr_adv) begin
        rr_ptr <= (arb_id == buf_id_t'(N_FIFO_OUT_BUFFER - 1)) ? '0 : arb_id + 1'b1;
      end
    end
  end

  always_comb begin
    bus.credit_available_o = '0;
    for (int unsigned v = 0; v < N_TOT_OF_VC; v++) begin
      bus.credit_available_o[v] = (credit[v] != '0);
    end
  end

  assign bus.g_la_o                    = grant;
  assign bus.g_la_fifo_out_buffer_id_o = grant ? arb_id : '0;
  assign bus.credit_overflow_o         = overflow;

endmodule

// File: tb/tb_link_allocator.sv
// Self-checking bench for link_allocator against a per-buffer/per-VC behavioural model.
module tb_link_allocator;
  import link_allocator_pkg::*;

  localparam int NB = N_FIFO_OUT_BUFFER;
  localparam int NV = N_TOT_OF_VC;
  localparam int VW = N_BITS_VC_ID;

  logic clk = 1'b0;
  logic rst = 1'b0;

  link_allocator_if bus ();

  link_allocator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int m_credit [NV];
  int m_ptr  = 0;
  int m_lock = -1;
  bit m_ovf  = 1'b0;

  bit eg;
  int eid;

  function automatic int vc_of(int b);
    logic [VW-1:0] s;
    s = bus.buffer_vc_i[b*VW +: VW];
    return int'(s);
  endfunction

  task automatic set_vc(int b, int v);
    bus.buffer_vc_i[b*VW +: VW] = VW'(v);
  endtask

  function automatic void model_arb(output bit g, output int id);
    int b;
    g  = 1'b0;
    id = 0;
    if (rst !== 1'b1) return;
    for (int k = 0; k < NB; k++) begin
      b = (m_ptr + k) % NB;
      if (!g && bus.r_la_i[b] && m_credit[vc_of(b)] > 0 && (m_lock < 0 || m_lock == b)) begin
        g  = 1'b1;
        id = b;
      end
    end
  endfunction

  function automatic logic [NV-1:0] model_avail();
    logic [NV-1:0] a;
    for (int v = 0; v < NV; v++) a[v] = (m_credit[v] != 0);
    return a;
  endfunction

  task automatic clock_edge();
    bit g;
    int id;
    bit dec;
    model_arb(g, id);
    if (rst !== 1'b1) begin
      for (int v = 0; v < NV; v++) m_credit[v] = CREDIT_MAX;
      m_ptr  = 0;
      m_lock = -1;
      m_ovf  = 1'b0;
    end else begin
      for (int v = 0; v < NV; v++) begin
        dec = g && (vc_of(id) == v);
        if (bus.credit_in_i[v] && !dec) begin
          if (m_credit[v] == CREDIT_MAX) m_ovf = 1'b1;
          else m_credit[v]++;
        end else if (dec && !bus.credit_in_i[v]) begin
          m_credit[v]--;
        end
      end
      if (g) begin
`ifdef LA_PACKET_LOCK_EN
        if (bus.buffer_tail_i[id]) begin
          m_lock = -1;
          m_ptr  = (id + 1) % NB;
        end else begin
          m_lock = id;
        end
`else
        m_ptr = (id + 1) % NB;
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clock_edge();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bus.r_la_i = '1;
    bus.buffer_vc_i = '0;
    bus.buffer_tail_i = '1;
    bus.credit_in_i = '0;
    rst = 1'b0;
    clock_edge();
    clock_edge();
    n_checks++;
    if (bus.g_la_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_g: got %b expected 0", bus.g_la_o);
    end
    n_checks++;
    if (bus.g_la_fifo_out_buffer_id_o !== '0) begin
      n_fail++; $display("FAIL reset_id: got %0d expected 0", bus.g_la_fifo_out_buffer_id_o);
    end
    n_checks++;
    if (bus.credit_available_o !== {NV{1'b1}}) begin
      n_fail++; $display("FAIL reset_avail: got %b expected all ones", bus.credit_available_o);
    end
    n_checks++;
    if (bus.credit_overflow_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ovf: got %b expected 0", bus.credit_overflow_o);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.g_la_o !== 1'b1 || bus.g_la_fifo_out_buffer_id_o !== '0) begin
      n_fail++; $display("FAIL reset_first_grant: got g=%b id=%0d expected g=1 id=0",
                         bus.g_la_o, bus.g_la_fifo_out_buffer_id_o);
    end
    clock_edge();
  endtask

  task automatic test_rr();
    do_reset();
    bus.r_la_i = 6'b000101;
    bus.buffer_tail_i = '1;
    set_vc(0, 0);
    set_vc(2, 2);
    for (int i = 0; i < 8; i++) begin
      #1;
      model_arb(eg, eid);
      n_checks++;
      if (bus.g_la_o !== eg || int'(bus.g_la_fifo_out_buffer_id_o) != eid) begin
        n_fail++; $display("FAIL rr_cycle%0d: got g=%b id=%0d expected g=%b id=%0d",
                           i, bus.g_la_o, bus.g_la_fifo_out_buffer_id_o, eg, eid);
      end
      clock_edge();
    end
    bus.r_la_i = 6'b100000;
    set_vc(5, 3);
    #1;
    n_checks++;
    if (bus.g_la_o !== 1'b1 || bus.g_la_fifo_out_buffer_id_o !== 3'd5) begin
      n_fail++; $display("FAIL rr_last: got g=%b id=%0d expected g=1 id=5",
                         bus.g_la_o, bus.g_la_fifo_out_buffer_id_o);
    end
    clock_edge();
    bus.r_la_i = 6'b000011;
    set_vc(1, 1);
    #1;
    n_checks++;
    if (bus.g_la_o !== 1'b1 || bus.g_la_fifo_out_buffer_id_o !== 3'd0) begin
      n_fail++; $display("FAIL rr_wrap: got g=%b id=%0d expected g=1 id=0",
                         bus.g_la_o, bus.g_la_fifo_out_buffer_id_o);
    end
    clock_edge();
  endtask

  task automatic test_credit();
    int grants;
    do_reset();
    grants = 0;
    bus.r_la_i = 6'b000001;
    bus.buffer_tail_i = '1;
    set_vc(0, 0);
    for (int i = 0; i < 11; i++) begin
      #1;
      model_arb(eg, eid);
      n_checks++;
      if (bus.g_la_o !== eg || int'(bus.g_la_fifo_out_buffer_id_o) != eid) begin
        n_fail++; $display("FAIL credit_cycle%0d: got g=%b id=%0d expected g=%b id=%0d",
                           i, bus.g_la_o, bus.g_la_fifo_out_buffer_id_o, eg, eid);
      end
      if (bus.g_la_o === 1'b1) grants++;
      clock_edge();
    end
    n_checks++;
    if (grants != int'(CREDIT_MAX)) begin
      n_fail++; $display("FAIL credit_count: got %0d grants expected %0d", grants, CREDIT_MAX);
    end
    n_checks++;
    if (bus.credit_available_o[0] !== 1'b0) begin
      n_fail++; $display("FAIL credit_empty: got avail0=%b expected 0", bus.credit_available_o[0]);
    end
    bus.credit_in_i = 4'b0001;
    clock_edge();
    bus.credit_in_i = '0;
    grants = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      model_arb(eg, eid);
      n_checks++;
      if (bus.g_la_o !== eg || bus.credit_available_o !== model_avail()) begin
        n_fail++; $display("FAIL credit_return%0d: got g=%b avail=%b expected g=%b avail=%b",
                           i, bus.g_la_o, bus.credit_available_o, eg, model_avail());
      end
      if (bus.g_la_o === 1'b1) grants++;
      clock_edge();
    end
    n_checks++;
    if (grants != 1) begin
      n_fail++; $display("FAIL credit_one_more: got %0d grants expected 1", grants);
    end
  endtask

  task automatic test_simultaneous();
    int grants;
    do_reset();
    bus.r_la_i = 6'b000010;
    bus.buffer_tail_i = '1;
    set_vc(1, 1);
    for (int i = 0; i < 5; i++) clock_edge();
    bus.credit_in_i = 4'b0010;
    #1;
    n_checks++;
    if (bus.g_la_o !== 1'b1) begin
      n_fail++; $display("FAIL simul_grant: got g=%b expected 1", bus.g_la_o);
    end
    clock_edge();
    bus.credit_in_i = '0;
    grants = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      model_arb(eg, eid);
      n_checks++;
      if (bus.g_la_o !== eg) begin
        n_fail++; $display("FAIL simul_cycle%0d: got g=%b expected %b", i, bus.g_la_o, eg);
      end
      if (bus.g_la_o === 1'b1) grants++;
      clock_edge();
    end
    n_checks++;
    if (grants != 3) begin
      n_fail++; $display("FAIL simul_credit: got %0d grants expected 3", grants);
    end
    bus.r_la_i = '0;
    n_checks++;
    if (bus.credit_overflow_o !== 1'b0) begin
      n_fail++; $display("FAIL ovf_before: got %b expected 0", bus.credit_overflow_o);
    end
    bus.credit_in_i = 4'b0100;
    clock_edge();
    bus.credit_in_i = '0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.credit_overflow_o !== 1'b1 || m_ovf !== 1'b1) begin
        n_fail++; $display("FAIL ovf_sticky%0d: got %b expected 1", i, bus.credit_overflow_o);
      end
      clock_edge();
    end
  endtask

  task automatic test_lock();
    int b1_grants;
    int seq [5];
    int exp_seq [5];
`ifdef LA_PACKET_LOCK_EN
    exp_seq = '{1, 1, 1, 1, 3};
`else
    exp_seq = '{1, 3, 1, 3, 1};
`endif
    do_reset();
    b1_grants = 0;
    bus.r_la_i = 6'b001010;
    bus.buffer_tail_i = '1;
    bus.buffer_tail_i[1] = 1'b0;
    set_vc(1, 1);
    set_vc(3, 3);
    for (int i = 0; i < 5; i++) begin
      #1;
      model_arb(eg, eid);
      seq[i] = int'(bus.g_la_fifo_out_buffer_id_o);
      n_checks++;
      if (bus.g_la_o !== 1'b1 || seq[i] != exp_seq[i] || seq[i] != eid) begin
        n_fail++; $display("FAIL lock_seq%0d: got g=%b id=%0d expected g=1 id=%0d",
                           i, bus.g_la_o, seq[i], exp_seq[i]);
      end
      if (seq[i] == 1) b1_grants++;
      clock_edge();
      bus.buffer_tail_i[1] = (b1_grants >= 3);
    end
    do_reset();
    bus.buffer_tail_i[1] = 1'b0;
    for (int i = 0; i < 14; i++) begin
      #1;
      model_arb(eg, eid);
      n_checks++;
      if (bus.g_la_o !== eg || int'(bus.g_la_fifo_out_buffer_id_o) != eid) begin
        n_fail++; $display("FAIL lock_stall%0d: got g=%b id=%0d expected g=%b id=%0d",
                           i, bus.g_la_o, bus.g_la_fifo_out_buffer_id_o, eg, eid);
      end
      clock_edge();
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    bus.r_la_i = 6'b010000;
    bus.buffer_tail_i = '0;
    set_vc(4, 2);
    for (int i = 0; i < 6; i++) clock_edge();
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.g_la_o !== 1'b0) begin
      n_fail++; $display("FAIL midrst_g: got %b expected 0", bus.g_la_o);
    end
    clock_edge();
    rst = 1'b1;
    bus.r_la_i = 6'b010100;
    bus.buffer_tail_i = '1;
    set_vc(2, 0);
    #1;
    model_arb(eg, eid);
    n_checks++;
    if (bus.credit_available_o !== {NV{1'b1}}) begin
      n_fail++; $display("FAIL midrst_avail: got %b expected all ones", bus.credit_available_o);
    end
    n_checks++;
    if (bus.g_la_o !== 1'b1 || bus.g_la_fifo_out_buffer_id_o !== 3'd2 || eid != 2) begin
      n_fail++; $display("FAIL midrst_grant: got g=%b id=%0d expected g=1 id=2",
                         bus.g_la_o, bus.g_la_fifo_out_buffer_id_o);
    end
    clock_edge();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.r_la_i        = NB'($urandom);
      bus.buffer_vc_i   = (NB*VW)'($urandom);
      bus.buffer_tail_i = NB'($urandom);
      bus.credit_in_i   = NV'($urandom & $urandom & $urandom);
      #1;
      model_arb(eg, eid);
      n_checks++;
      if (bus.g_la_o !== eg || int'(bus.g_la_fifo_out_buffer_id_o) != eid ||
          bus.credit_available_o !== model_avail() || bus.credit_overflow_o !== m_ovf) begin
        n_fail++; $display("FAIL random%0d: got g=%b id=%0d avail=%b ovf=%b expected g=%b id=%0d avail=%b ovf=%b",
                           i, bus.g_la_o, bus.g_la_fifo_out_buffer_id_o, bus.credit_available_o,
                           bus.credit_overflow_o, eg, eid, model_avail(), m_ovf);
      end
      clock_edge();
    end
  endtask

  initial begin
    for (int v = 0; v < NV; v++) m_credit[v] = CREDIT_MAX;
    bus.r_la_i = '0;
    bus.buffer_vc_i = '0;
    bus.buffer_tail_i = '0;
    bus.credit_in_i = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_rr();
    test_credit();
    test_simultaneous();
    test_lock();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
